// File: rtl/fwd_hazard_if.sv
// Decode-side bundle for the forwarding/hazard unit.
//   master : decode stage (drives instruction info and flush, reads back
//            operand-mux selects, the hold line and the stall counter)
//   slave  : fwd_hazard_unit
// Signals:
//   id_valid, id_rd_idx, id_rd_we, id_is_load : decode instruction info
//   id_rs_idx  : NUM_READ packed read indices, port p at [p*W +: W]
//   id_rs_used : per-port "actually reads a register"
//   flush      : squash every tracked instruction
//   mux_ctrl   : per-port select, 1 = register file, s = stage s
//   stall      : hold decode/fetch
//   stall_cnt  : saturating stall-cycle count
interface fwd_hazard_if #(
    parameter int REG_IDX_W = 4,
    parameter int NUM_READ  = 2,
    parameter int FWD_DEPTH = 2
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 2);

    logic                          id_valid;
    logic [REG_IDX_W-1:0]          id_rd_idx;
    logic                          id_rd_we;
    logic                          id_is_load;
    logic [NUM_READ*REG_IDX_W-1:0] id_rs_idx;
    logic [NUM_READ-1:0]           id_rs_used;
    logic                          flush;
    logic [NUM_READ*SEL_W-1:0]     mux_ctrl;
    logic                          stall;
    logic [15:0]                   stall_cnt;

    modport master (
        output id_valid, id_rd_idx, id_rd_we, id_is_load,
        output id_rs_idx, id_rs_used, flush,
        input  mux_ctrl, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rd_idx, id_rd_we, id_is_load,
        input  id_rs_idx, id_rs_used, flush,
        output mux_ctrl, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Tracks destination tags of in-flight instructions in stages 2..FWD_DEPTH+1,
// selects the youngest matching stage per read port, raises stall when the
// youngest producer is a load whose data is not yet forwardable, and counts
// stall cycles.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset (also forces mux_ctrl=1, stall=0)
//   bus : fwd_hazard_if.slave (see interface header for signal list)
module fwd_hazard_unit #(
    parameter int REG_IDX_W   = 4,
    parameter int NUM_READ    = 2,
    parameter int FWD_DEPTH   = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 0,
    parameter int SEL_W       = $clog2(FWD_DEPTH + 2)
) (
    input  logic        clk,
    input  logic        rst,
    fwd_hazard_if.slave bus
);

    // Tag storage; array index i holds pipeline stage i+2.
    logic                 tag_we_q  [FWD_DEPTH];
    logic [REG_IDX_W-1:0] tag_idx_q [FWD_DEPTH];
    logic                 tag_ld_q  [FWD_DEPTH];
    logic                 tag_we_d  [FWD_DEPTH];
    logic [REG_IDX_W-1:0] tag_idx_d [FWD_DEPTH];
    logic                 tag_ld_d  [FWD_DEPTH];

    logic [15:0]          stall_cnt_q;
    logic [15:0]          stall_cnt_d;

    logic [NUM_READ-1:0]  port_hz;
    logic                 stall_w;

    // ------------------------------------------------------------------
    // Per-port select and hazard; ports are fully independent.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_port
            logic [REG_IDX_W-1:0] rs;
            logic                 zero_blk;
            logic [SEL_W-1:0]     sel;
            logic                 hz;

            assign rs       = bus.id_rs_idx[gi*REG_IDX_W +: REG_IDX_W];
            assign zero_blk = (ZERO_REG_EN != 0) && (rs == '0);

            // Scan oldest to youngest so the youngest match overwrites.
            // The hazard flag follows the youngest match only, so a younger
            // non-load producer hides an older load.
            always_comb begin
                sel = SEL_W'(1);
                hz  = 1'b0;
                for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
                    if (bus.id_rs_used[gi] && !zero_blk &&
                        tag_we_q[i] && (tag_idx_q[i] == rs)) begin
                        sel = SEL_W'(i + 2);
                        hz  = tag_ld_q[i] && (i < LOAD_LAT);
                    end
                end
            end

            assign bus.mux_ctrl[gi*SEL_W +: SEL_W] = rst ? SEL_W'(1) : sel;
            assign port_hz[gi] = hz;
        end
    endgenerate

    // Flush and reset both suppress the hold line in their cycle.
    assign stall_w       = bus.id_valid && (|port_hz) && !bus.flush && !rst;
    assign bus.stall     = stall_w;
    assign bus.stall_cnt = stall_cnt_q;

    // ------------------------------------------------------------------
    // Next-state: capture into stage 2 unless stalled, shift the rest.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < FWD_DEPTH; i++) begin
            tag_we_d[i]  = 1'b0;
            tag_idx_d[i] = '0;
            tag_ld_d[i]  = 1'b0;
        end

        if (!bus.flush) begin
            if (bus.id_valid && !stall_w) begin
                tag_we_d[0]  = bus.id_rd_we;
                tag_idx_d[0] = bus.id_rd_idx;
                tag_ld_d[0]  = bus.id_is_load;
            end
            for (int i = 1; i < FWD_DEPTH; i++) begin
                tag_we_d[i]  = tag_we_q[i-1];
                tag_idx_d[i] = tag_idx_q[i-1];
                tag_ld_d[i]  = tag_ld_q[i-1];
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                tag_we_q[i]  <= 1'b0;
                tag_idx_q[i] <= '0;
                tag_ld_q[i]  <= 1'b0;
            end
            stall_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                tag_we_q[i]  <= tag_we_d[i];
                tag_idx_q[i] <= tag_idx_d[i];
                tag_ld_q[i]  <= tag_ld_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a: defaults, z: ZERO_REG_EN=1 (same stimulus as a), d: depth 4 / load lat 2
    fwd_hazard_if #(.REG_IDX_W(4), .NUM_READ(2), .FWD_DEPTH(2)) bus_a ();
    fwd_hazard_if #(.REG_IDX_W(4), .NUM_READ(2), .FWD_DEPTH(2)) bus_z ();
    fwd_hazard_if #(.REG_IDX_W(4), .NUM_READ(2), .FWD_DEPTH(4)) bus_d ();

    fwd_hazard_unit #(.FWD_DEPTH(2), .LOAD_LAT(1), .ZERO_REG_EN(0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    fwd_hazard_unit #(.FWD_DEPTH(2), .LOAD_LAT(1), .ZERO_REG_EN(1)) dut_z (
        .clk(clk), .rst(rst), .bus(bus_z.slave));
    fwd_hazard_unit #(.FWD_DEPTH(4), .LOAD_LAT(2), .ZERO_REG_EN(0)) dut_d (
        .clk(clk), .rst(rst), .bus(bus_d.slave));

    assign bus_z.id_valid   = bus_a.id_valid;
    assign bus_z.id_rd_idx  = bus_a.id_rd_idx;
    assign bus_z.id_rd_we   = bus_a.id_rd_we;
    assign bus_z.id_is_load = bus_a.id_is_load;
    assign bus_z.id_rs_idx  = bus_a.id_rs_idx;
    assign bus_z.id_rs_used = bus_a.id_rs_used;
    assign bus_z.flush      = bus_a.flush;

    typedef struct {
        string       name;
        int          dut;    // 0=a 1=z 2=d
        int          field;  // 0=port0 sel 1=port1 sel 2=stall 3=stall_cnt
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] observe(int d, int f);
        logic [15:0] v;
        v = 16'hDEAD;
        case (d)
            0: case (f)
                0: v = {14'd0, bus_a.mux_ctrl[1:0]};
                1: v = {14'd0, bus_a.mux_ctrl[3:2]};
                2: v = {15'd0, bus_a.stall};
                default: v = bus_a.stall_cnt;
            endcase
            1: case (f)
                0: v = {14'd0, bus_z.mux_ctrl[1:0]};
                1: v = {14'd0, bus_z.mux_ctrl[3:2]};
                2: v = {15'd0, bus_z.stall};
                default: v = bus_z.stall_cnt;
            endcase
            default: case (f)
                0: v = {13'd0, bus_d.mux_ctrl[2:0]};
                1: v = {13'd0, bus_d.mux_ctrl[5:3]};
                2: v = {15'd0, bus_d.stall};
                default: v = bus_d.stall_cnt;
            endcase
        endcase
        return v;
    endfunction

    task automatic expect_(input string name, input int d, input int f, input logic [15:0] e);
        sb_item_t it;
        it.name = name; it.dut = d; it.field = f; it.exp = e;
        sb_q.push_back(it);
    endtask

    task automatic check_all();
        sb_item_t it;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            obs = observe(it.dut, it.field);
            total++;
            assert (obs === it.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", it.name, obs, it.exp);
            end
            $display("check %-14s dut=%0d field=%0d obs=%0h exp=%0h",
                     it.name, it.dut, it.field, obs, it.exp);
        end
    endtask

    // Check at the falling edge, then advance past the next rising edge.
    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic [3:0] rd, input logic we, input logic ld,
                         input logic [3:0] rs0, input logic [3:0] rs1,
                         input logic [1:0] used, input logic fl);
        bus_a.id_valid   = v;
        bus_a.id_rd_idx  = rd;
        bus_a.id_rd_we   = we;
        bus_a.id_is_load = ld;
        bus_a.id_rs_idx  = {rs1, rs0};
        bus_a.id_rs_used = used;
        bus_a.flush      = fl;
    endtask

    task automatic drv_d(input logic v, input logic [3:0] rd, input logic we, input logic ld,
                         input logic [3:0] rs0, input logic [3:0] rs1,
                         input logic [1:0] used, input logic fl);
        bus_d.id_valid   = v;
        bus_d.id_rd_idx  = rd;
        bus_d.id_rd_we   = we;
        bus_d.id_is_load = ld;
        bus_d.id_rs_idx  = {rs1, rs0};
        bus_d.id_rs_used = used;
        bus_d.flush      = fl;
    endtask

    initial begin
        rst = 1'b1;
        drv_a(0, 0, 0, 0, 0, 0, 2'b00, 0);
        drv_d(0, 0, 0, 0, 0, 0, 2'b00, 0);
        @(posedge clk);
        #1;
        // Reset state
        expect_("rst_a_p0", 0, 0, 16'd1);
        expect_("rst_a_p1", 0, 1, 16'd1);
        expect_("rst_a_stall", 0, 2, 16'd0);
        expect_("rst_a_cnt", 0, 3, 16'd0);
        expect_("rst_d_cnt", 2, 3, 16'd0);
        cyc();
        rst = 1'b0;

        // Basic forwarding: r3 then r5, read (r3,r5)
        drv_a(1, 3, 1, 0, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 5, 1, 0, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 0, 0, 0, 3, 5, 2'b11, 0);
        expect_("add_p0", 0, 0, 16'd3);
        expect_("add_p1", 0, 1, 16'd2);
        expect_("add_stall", 0, 2, 16'd0);
        expect_("add_z_p0", 1, 0, 16'd3);
        cyc();

        // Youngest wins: r4 in both stages
        drv_a(1, 4, 1, 0, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 4, 1, 0, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 0, 0, 0, 4, 4, 2'b11, 0);
        expect_("young_p0", 0, 0, 16'd2);
        expect_("young_p1", 0, 1, 16'd2);
        cyc();

        // Per-port independence: stage3=r2, stage2=r1, read (r2,r1)
        drv_a(1, 2, 1, 0, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 1, 1, 0, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 0, 0, 0, 2, 1, 2'b11, 0);
        expect_("indep_p0", 0, 0, 16'd3);
        expect_("indep_p1", 0, 1, 16'd2);
        cyc();

        // Load-use: load r6, reader (writes r8) reads (r6,r8)
        drv_a(1, 6, 1, 1, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 8, 1, 0, 6, 8, 2'b11, 0);
        expect_("lu_stall", 0, 2, 16'd1);
        expect_("lu_p0", 0, 0, 16'd2);
        expect_("lu_p1", 0, 1, 16'd1);
        cyc();
        expect_("lu_rel_stall", 0, 2, 16'd0);
        expect_("lu_rel_p0", 0, 0, 16'd3);
        expect_("lu_bubble_p1", 0, 1, 16'd1);
        expect_("lu_cnt", 0, 3, 16'd1);
        cyc();

        // Zero register: r0 written, read (r0,r8)
        drv_a(1, 0, 1, 0, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 0, 0, 0, 0, 8, 2'b11, 0);
        expect_("zero_a_p0", 0, 0, 16'd2);
        expect_("zero_a_p1", 0, 1, 16'd3);
        expect_("zero_z_p0", 1, 0, 16'd1);
        expect_("zero_z_p1", 1, 1, 16'd3);
        cyc();
        // Load to r0: only the ZERO_REG_EN=0 instance stalls
        drv_a(1, 0, 1, 1, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 0, 0, 0, 0, 0, 2'b01, 0);
        expect_("zld_a_stall", 0, 2, 16'd1);
        expect_("zld_z_stall", 1, 2, 16'd0);
        expect_("zld_z_p0", 1, 0, 16'd1);
        cyc();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00, 0);
        expect_("zld_a_cnt", 0, 3, 16'd2);
        expect_("zld_z_cnt", 1, 3, 16'd1);
        cyc();

        // Flush over a load-use hazard
        drv_a(1, 7, 1, 1, 0, 0, 2'b00, 0); cyc();
        drv_a(1, 0, 0, 0, 7, 0, 2'b01, 1);
        expect_("fl_stall", 0, 2, 16'd0);
        expect_("fl_p0", 0, 0, 16'd2);
        cyc();
        drv_a(1, 0, 0, 0, 7, 0, 2'b01, 0);
        expect_("fl_after_p0", 0, 0, 16'd1);
        expect_("fl_after_stall", 0, 2, 16'd0);
        expect_("fl_cnt", 0, 3, 16'd2);
        cyc();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00, 0);

        // Deep pipe: load r9 with two stall cycles
        drv_d(1, 9, 1, 1, 0, 0, 2'b00, 0); cyc();
        drv_d(1, 0, 0, 0, 9, 0, 2'b01, 0);
        expect_("deep_st1", 2, 2, 16'd1);
        expect_("deep_p0_1", 2, 0, 16'd2);
        cyc();
        expect_("deep_st2", 2, 2, 16'd1);
        expect_("deep_p0_2", 2, 0, 16'd3);
        cyc();
        expect_("deep_st3", 2, 2, 16'd0);
        expect_("deep_p0_3", 2, 0, 16'd4);
        expect_("deep_cnt", 2, 3, 16'd2);
        cyc();

        // Reset during the first stall cycle
        drv_d(1, 9, 1, 1, 0, 0, 2'b00, 0); cyc();
        drv_d(1, 0, 0, 0, 9, 0, 2'b01, 0);
        expect_("rs_pre_stall", 2, 2, 16'd1);
        @(negedge clk);
        check_all();
        #2;
        rst = 1'b1;
        #1;
        expect_("rs_stall", 2, 2, 16'd0);
        expect_("rs_p0", 2, 0, 16'd1);
        expect_("rs_p1", 2, 1, 16'd1);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_("rs_d_cnt", 2, 3, 16'd0);
        expect_("rs_a_cnt", 0, 3, 16'd0);
        expect_("rs_tags_p0", 2, 0, 16'd1);
        expect_("rs_tags_stall", 2, 2, 16'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
